// File: rtl/imem_fetch_unit.sv
// imem_fetch_unit: sequential fetch from a 1-cycle synchronous instruction memory into a skid buffer.
// Optional feature: define FETCH_PERF_EN to add the bubble/redirect performance counters.

module imem_fetch_unit_chk #(
    parameter int unsigned CW    = 2,
    parameter int unsigned DEPTH = 2
) (
    input logic          clk,
    input logic          reset,
    input logic          push,
    input logic [CW-1:0] count
);
    // Every returning read must find a free slot; the issue rule reserves one per read in flight
    a_no_push_when_full: assert property (@(posedge clk) disable iff (reset)
        push |-> (32'(count) < DEPTH));
endmodule

module imem_fetch_unit #(
    parameter int unsigned              ADDRESS_WIDTH = 12,
    parameter int unsigned              DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = {ADDRESS_WIDTH{1'b0}},
    parameter int unsigned              BUF_DEPTH     = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic                     mem_wEn,
    output logic [DATA_WIDTH-1:0]    mem_dataIn,
    input  logic [DATA_WIDTH-1:0]    mem_dataOut,
    output logic                     inst_valid,
    input  logic                     inst_ready,
    output logic [DATA_WIDTH-1:0]    inst_data,
    output logic [ADDRESS_WIDTH-1:0] inst_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]              perf_bubble_cnt,
    output logic [31:0]              perf_redirect_cnt
`endif
);
    localparam int unsigned PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CW = $clog2(BUF_DEPTH + 1);
    localparam logic [CW:0]            DEPTH_C = (CW+1)'(BUF_DEPTH);
    localparam logic [CW-1:0]          CNT_ONE = CW'(1'b1);
    localparam logic [PW-1:0]          PTR_ONE = PW'(1'b1);
    localparam logic [ADDRESS_WIDTH-1:0] PC_ONE = ADDRESS_WIDTH'(1'b1);

    logic [ADDRESS_WIDTH-1:0] fetch_pc_r, fetch_pc_nxt_s;
    logic                     inflight_r, inflight_nxt_s;
    logic [ADDRESS_WIDTH-1:0] inflight_pc_r, inflight_pc_nxt_s;
    logic [CW-1:0]            count_r, count_nxt_s;
    logic [PW-1:0]            rd_ptr_r, rd_ptr_nxt_s;
    logic [PW-1:0]            wr_ptr_r, wr_ptr_nxt_s;
    logic                     valid_r;
    logic [DATA_WIDTH-1:0]    buf_data_r [BUF_DEPTH];
    logic [ADDRESS_WIDTH-1:0] buf_pc_r   [BUF_DEPTH];

    logic        pop_s;
    logic        push_s;
    logic        issue_s;
    logic [CW:0] occ_s;

    // Occupancy counts the slot already promised to the read in flight
    assign pop_s   = valid_r & inst_ready;
    assign push_s  = inflight_r & ~reset & ~redirect_valid;
    assign occ_s   = (CW+1)'(count_r) + (CW+1)'(inflight_r) - (CW+1)'(pop_s);
    assign issue_s = ~reset & ~redirect_valid & (occ_s < DEPTH_C);

    // Next-state for fetch pointer, in-flight read and buffer bookkeeping
    always_comb begin
        fetch_pc_nxt_s    = fetch_pc_r;
        inflight_nxt_s    = 1'b0;
        inflight_pc_nxt_s = inflight_pc_r;
        count_nxt_s       = count_r;
        rd_ptr_nxt_s      = rd_ptr_r;
        wr_ptr_nxt_s      = wr_ptr_r;
        if (redirect_valid) begin
            fetch_pc_nxt_s = redirect_pc;
            count_nxt_s    = {CW{1'b0}};
            rd_ptr_nxt_s   = {PW{1'b0}};
            wr_ptr_nxt_s   = {PW{1'b0}};
        end else begin
            if (issue_s) begin
                inflight_nxt_s    = 1'b1;
                inflight_pc_nxt_s = fetch_pc_r;
                fetch_pc_nxt_s    = fetch_pc_r + PC_ONE;
            end else begin
                inflight_nxt_s    = 1'b0;
            end
            if (push_s) begin
                wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_nxt_s = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_nxt_s = rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_nxt_s = count_r + CNT_ONE;
                2'b01:   count_nxt_s = count_r - CNT_ONE;
                default: count_nxt_s = count_r;
            endcase
        end
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_r    <= RESET_PC;
            inflight_r    <= 1'b0;
            inflight_pc_r <= {ADDRESS_WIDTH{1'b0}};
            count_r       <= {CW{1'b0}};
            rd_ptr_r      <= {PW{1'b0}};
            wr_ptr_r      <= {PW{1'b0}};
            valid_r       <= 1'b0;
        end else begin
            fetch_pc_r    <= fetch_pc_nxt_s;
            inflight_r    <= inflight_nxt_s;
            inflight_pc_r <= inflight_pc_nxt_s;
            count_r       <= count_nxt_s;
            rd_ptr_r      <= rd_ptr_nxt_s;
            wr_ptr_r      <= wr_ptr_nxt_s;
            valid_r       <= (count_nxt_s != {CW{1'b0}});
        end
    end

    // Buffer storage; entries only become visible through count, so no reset is needed
    always_ff @(posedge clk) begin
        if (push_s) begin
            buf_data_r[wr_ptr_r] <= mem_dataOut;
            buf_pc_r[wr_ptr_r]   <= inflight_pc_r;
        end
    end

    assign mem_addr   = fetch_pc_r;
    assign mem_wEn    = 1'b0;
    assign mem_dataIn = {DATA_WIDTH{1'b0}};
    assign inst_valid = valid_r;
    assign inst_data  = buf_data_r[rd_ptr_r];
    assign inst_pc    = buf_pc_r[rd_ptr_r];

`ifdef FETCH_PERF_EN
    logic [31:0] bubble_cnt_r;
    logic [31:0] redirect_cnt_r;

    // Performance counters: starved-consumer cycles and redirect cycles, wrapping at 2^32
    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt_r   <= 32'd0;
            redirect_cnt_r <= 32'd0;
        end else begin
            if (inst_ready & ~valid_r) begin
                bubble_cnt_r <= bubble_cnt_r + 32'd1;
            end
            if (redirect_valid) begin
                redirect_cnt_r <= redirect_cnt_r + 32'd1;
            end
        end
    end

    assign perf_bubble_cnt   = bubble_cnt_r;
    assign perf_redirect_cnt = redirect_cnt_r;
`endif

    imem_fetch_unit_chk #(
        .CW    (CW),
        .DEPTH (BUF_DEPTH)
    ) u_chk (
        .clk   (clk),
        .reset (reset),
        .push  (inflight_r),
        .count (count_r)
    );

endmodule
